// File: rtl/ir_car_scheduler_if.sv
// Bus and transmitter-control bundle between the peripheral decoder, the scheduler and the IR transmitter.
// Latency: none; this is wiring only.
// Backpressure: none; bus writes are single-cycle strobes that are always accepted.
interface ir_car_scheduler_if;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [3:0] COMMAND;
    logic [1:0] CAR_SEL;
    logic       pack_strobe;
    logic       pack_gen_EN;
    logic       BUSY;

    modport master (
        output BUS_ADDR, BUS_DATA, BUS_WE,
        input  COMMAND, CAR_SEL, pack_strobe, pack_gen_EN, BUSY
    );

    modport slave (
        input  BUS_ADDR, BUS_DATA, BUS_WE,
        output COMMAND, CAR_SEL, pack_strobe, pack_gen_EN, BUSY
    );
endinterface

// File: rtl/ir_car_scheduler.sv
// Round-robin IR transmitter scheduler: per-car command registers, one slot of SLOT_PACKETS strobes per enabled car.
// Latency: mask write -> SELECT two cycles later -> TRANSMIT (pack_gen_EN) three cycles later; outputs registered.
// Backpressure: none; bus writes always land. Optional IR_SCHED_TIMEOUT_EN clears stale commands after TIMEOUT_SLOTS slots.
module ir_car_scheduler #(
    parameter int unsigned STROBE_PERIOD = 10_000_000,
    parameter int unsigned STROBE_WIDTH  = 24,
    parameter int unsigned SLOT_PACKETS  = 10,
    parameter logic [7:0]  BASE_ADDR     = 8'h90,
    parameter int unsigned TIMEOUT_SLOTS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    ir_car_scheduler_if.slave bus
);

    localparam int unsigned SLOT_W = (SLOT_PACKETS > 1) ? $clog2(SLOT_PACKETS) : 1;
    localparam logic [STROBE_WIDTH-1:0] LAST_CNT  = STROBE_WIDTH'(STROBE_PERIOD - 1);
    localparam logic [SLOT_W-1:0]       LAST_SLOT = SLOT_W'(SLOT_PACKETS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        TRANSMIT = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cmd [4];
    logic [3:0]              enable_mask;
    logic [1:0]              last_car;
    logic [STROBE_WIDTH-1:0] strobe_cnt;
    logic [SLOT_W-1:0]       slot_cnt;

    logic [3:0] command_q;
    logic [1:0] car_sel_q;
    logic       strobe_q;
    logic       pen_q;
    logic       busy_q;

    // Bus decode: offset 0..3 are the car commands, 4 is the enable mask.
    logic [7:0] offset;
    logic       wr_cmd;
    logic       wr_mask;
    logic [1:0] wr_idx;
    assign offset  = bus.BUS_ADDR - BASE_ADDR;
    assign wr_cmd  = bus.BUS_WE && (offset < 8'd4);
    assign wr_mask = bus.BUS_WE && (offset == 8'd4);
    assign wr_idx  = offset[1:0];

    // Upper data bits carry no register content.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.BUS_DATA[7:4];

    logic at_strobe;
    logic slot_end;
    logic [STROBE_WIDTH-1:0] cnt_next;
    assign at_strobe = (state == TRANSMIT) && (strobe_cnt == LAST_CNT);
    assign slot_end  = at_strobe && (slot_cnt == LAST_SLOT);
    assign cnt_next  = (strobe_cnt == LAST_CNT) ? '0 : strobe_cnt + 1'b1;

    // Pick the first enabled car after last_car, wrapping modulo 4 (last_car itself is tried last).
    logic [1:0] next_car;
    logic [1:0] cand;
    logic       found;
    always_comb begin
        next_car = last_car;
        cand     = last_car;
        found    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_car + 2'(k);
            if (!found && enable_mask[cand]) begin
                next_car = cand;
                found    = 1'b1;
            end
        end
    end

`ifdef IR_SCHED_TIMEOUT_EN
    logic [3:0] age [4];
    logic [4:0] age_inc;
    assign age_inc = {1'b0, age[car_sel_q]} + 5'd1;
`else
    localparam int unsigned unused_timeout_slots = TIMEOUT_SLOTS;
`endif

    // Register file; a bus write in the same cycle as a slot end wins over the timeout clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) cmd[i] <= '0;
            enable_mask <= '0;
`ifdef IR_SCHED_TIMEOUT_EN
            for (int i = 0; i < 4; i++) age[i] <= '0;
`endif
        end else begin
`ifdef IR_SCHED_TIMEOUT_EN
            if (slot_end) begin
                age[car_sel_q] <= age_inc[4] ? 4'hF : age_inc[3:0];
                if (age_inc >= 5'(TIMEOUT_SLOTS)) cmd[car_sel_q] <= '0;
            end
            if (wr_cmd) age[wr_idx] <= '0;
`endif
            if (wr_cmd)  cmd[wr_idx] <= bus.BUS_DATA[3:0];
            if (wr_mask) enable_mask <= bus.BUS_DATA[3:0];
        end
    end

    // Slot sequencer with registered outputs; COMMAND/CAR_SEL only change in SELECT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_car   <= 2'd3;
            strobe_cnt <= '0;
            slot_cnt   <= '0;
            command_q  <= '0;
            car_sel_q  <= '0;
            strobe_q   <= 1'b0;
            pen_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    strobe_q <= 1'b0;
                    pen_q    <= 1'b0;
                    if (enable_mask != 4'd0) begin
                        state  <= SELECT;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SELECT: begin
                    if (!found) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        command_q  <= cmd[next_car];
                        car_sel_q  <= next_car;
                        strobe_cnt <= '0;
                        slot_cnt   <= '0;
                        pen_q      <= 1'b1;
                        strobe_q   <= (LAST_CNT == '0);
                        state      <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (slot_end) begin
                        last_car   <= car_sel_q;
                        strobe_cnt <= '0;
                        slot_cnt   <= '0;
                        pen_q      <= 1'b0;
                        strobe_q   <= 1'b0;
                        state      <= (enable_mask != 4'd0) ? SELECT : IDLE;
                        busy_q     <= (enable_mask != 4'd0);
                    end else begin
                        strobe_cnt <= cnt_next;
                        strobe_q   <= (cnt_next == LAST_CNT);
                        if (at_strobe) slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    strobe_q <= 1'b0;
                    pen_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.COMMAND     = command_q;
    assign bus.CAR_SEL     = car_sel_q;
    assign bus.pack_strobe = strobe_q;
    assign bus.pack_gen_EN = pen_q;
    assign bus.BUSY        = busy_q;

endmodule

// File: doc/ir_car_scheduler.md
# ir_car_scheduler

Time-multiplexes the IR transmitter across up to four cars. Holds a per-car direction command written over the processor bus and generates the periodic `pack_strobe` and `pack_gen_EN` that drive the transmitter. Presents one car's command and car-select code for a full packet sequence (slot), then hands off round-robin to the next enabled car. Sits between the bus peripheral decoder and the IR transmitter state machine.

## Interface
- `STROBE_PERIOD`, 10_000_000: clock cycles between `pack_strobe` pulses (10 Hz at 100 MHz).
- `STROBE_WIDTH`, 24: width of the strobe counter; must satisfy 2^STROBE_WIDTH > STROBE_PERIOD.
- `SLOT_PACKETS`, 10: strobes per slot; matches the transmitter's packet-sequence length.
- `BASE_ADDR`, 8'h90: bus base address.
- `TIMEOUT_SLOTS`, 8: slots without a write before a command is cleared (only with macro).
- `CLK  in  1`: system clock; all logic on rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `BUS_ADDR  in  8`: bus address.
- `BUS_DATA  in  8`: bus write data.
- `BUS_WE  in  1`: write strobe, 1 cycle.
- `COMMAND  out  4`: direction code for the current slot (one-hot/pair encoding, 0 = IDLE).
- `CAR_SEL  out  2`: index of the car being served.
- `pack_strobe  out  1`: one-cycle pulse at each packet start.
- `pack_gen_EN  out  1`: high while a slot is active.
- `BUSY  out  1`: high in any state other than IDLE.

## Operation
- Registers: `cmd[0..3]` at BASE_ADDR+0..3 (data[3:0] only; [7:4] ignored). `enable_mask` at BASE_ADDR+4 (data[3:0]). Other addresses are ignored. Write-only; reset value 0.
- FSM states: IDLE, SELECT, TRANSMIT.
- IDLE: outputs inactive. If `enable_mask != 0`, go to SELECT next cycle.
- SELECT (1 cycle): choose the first enabled car strictly after `last_car`, in modulo-4 order. `last_car` resets to 3, so car 0 is served first. Latch `COMMAND <= cmd[car]` and `CAR_SEL <= car`. Clear the strobe counter and slot counter. Go to TRANSMIT. If the mask became 0 in this cycle, return to IDLE with outputs unchanged.
- TRANSMIT: `pack_gen_EN` is 1. The strobe counter counts 0..STROBE_PERIOD-1 and wraps. `pack_strobe` is 1 when the counter equals STROBE_PERIOD-1. Each strobe increments the slot counter.
- Slot end: the strobe with slot counter == SLOT_PACKETS-1 sets `last_car <= CAR_SEL`. Next state is SELECT if `enable_mask != 0`, otherwise IDLE.
- `COMMAND` and `CAR_SEL` are frozen for the whole slot.
  - A bus write to the served car's `cmd` mid-slot updates the register only. The change appears the next time that car is selected.
  - Disabling the served car mid-slot does not truncate the slot.
- A single enabled car is re-selected back-to-back. Each slot is preceded by one SELECT cycle.
- A write and a slot end in the same cycle: the write lands first, and SELECT in the next cycle sees the new value.

## Timing
- Reset values: COMMAND=0, CAR_SEL=0, pack_strobe=0, pack_gen_EN=0, BUSY=0, last_car=3, all registers 0, state IDLE.
- Mask write at cycle t:
  - register updated at t+1;
  - IDLE→SELECT at t+2;
  - TRANSMIT with `pack_gen_EN`=1 at t+3.
- First `pack_strobe` arrives STROBE_PERIOD-1 cycles after entry to TRANSMIT.
- Slot length: SLOT_PACKETS×STROBE_PERIOD cycles in TRANSMIT, plus 1 SELECT cycle.
- `pack_gen_EN` falls in the cycle after the final strobe of a slot (the SELECT or IDLE cycle).
- RST mid-slot: all outputs return to reset values on the next edge. No strobe is emitted in that cycle.

## Configuration
- `IR_SCHED_TIMEOUT_EN` defined:
  - Each car has a 4-bit slot-age counter. It is cleared by a write to that car's `cmd` and incremented at the end of each slot served to that car.
  - When the count reaches TIMEOUT_SLOTS, `cmd[car]` is cleared to 0 (IDLE). The car stops if the processor stops refreshing it.
- Undefined: commands persist until rewritten; no age counters are synthesised.

## Test plan
Parameters: STROBE_PERIOD=8, SLOT_PACKETS=3.
- Reset, then write mask=4'b0000 → BUSY, pack_gen_EN and pack_strobe stay 0 for 200 cycles.
- Write cmd0=4'b1000, cmd2=4'b0010, mask=4'b0101 → pack_gen_EN rises 3 cycles after the mask write. Sequence is CAR_SEL=0/COMMAND=8 for 3 strobes, then CAR_SEL=2/COMMAND=2, then car 0 again. Strobes are spaced 8 cycles apart.
- During car 0's slot, write cmd0=4'b0100 → COMMAND stays 8 until the slot ends; car 0's next slot shows 4.
- Write mask=0 after the first strobe of a slot → 2 more strobes occur, then IDLE with pack_gen_EN=0 and BUSY=0.
- Assert RST between strobes in TRANSMIT → next cycle all outputs are 0. After re-enable, car 0 is served first.
- With `IR_SCHED_TIMEOUT_EN` and TIMEOUT_SLOTS=2, enable car 1 only with cmd1=4'b1001 and no rewrites → the first 2 slots show COMMAND=9, the third shows COMMAND=0.
